// File: rtl/seg7_pkg.sv
// Shared seven-segment patterns (abcdefg order, active-low) and BCD helpers
// for the BCD counter and its digit decoders.
package seg7_pkg;

    localparam int MAX_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Binary-to-BCD for elaboration-time constants (preset and wrap value).
    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One-digit BCD to active-low seven-segment decoder; seg[6] = a, seg[0] = g.
// Non-decimal codes and the blank request both produce a dark digit.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            unique case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sync_bcd_counter.sv
// Button-stepped up/down BCD counter with load, hold, wrap pulse and
// seven-segment outputs with optional leading-zero blanking.
module sync_bcd_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 60,
    parameter int LOAD_VAL = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK_50,
    input  logic [0:0]            KEY,
    input  logic [3:3]            V_BT,
    input  logic [2:0]            SW,
    output logic [0:7*DIGITS-1]   HEX,
    output logic [4*DIGITS-1:0]   COUNT_BCD,
    output logic                  TC
);

    localparam int CW = 4 * DIGITS;
    localparam logic [CW-1:0] MAX_BCD  = CW'(to_bcd(MODULUS - 1));
    localparam logic [CW-1:0] LOAD_BCD = CW'(to_bcd(LOAD_VAL));

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("sync_bcd_counter: DIGITS must be 1..4");
    end
    if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
        $error("sync_bcd_counter: MODULUS must be 2..10^DIGITS");
    end
    if (LOAD_VAL < 0 || LOAD_VAL >= MODULUS) begin : g_bad_load
        $error("sync_bcd_counter: LOAD_VAL must be 0..MODULUS-1");
    end

    logic          sync1, sync2, prev;
    logic          primed, armed;
    logic          step;
    logic [CW-1:0] count_q, count_inc, count_dec;
    logic          tc_q;
    logic          at_max, at_zero;
    logic [DIGITS-1:0] blank;

    // A press held across reset must be released before it can step again:
    // "armed" only sets once the synchroniser has truly sampled the button low.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, giving a true shift register.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= V_BT[3];
            sync2  <= sync1;
            prev   <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1);
        end
    end

    assign step = sync2 & ~prev & armed;

    // NOTE: carry/borrow are block-local temporaries assigned with blocking (=)
    // and given defaults first, so the ripple is evaluated in order and no
    // latch is inferred.
    always_comb begin
        logic carry;
        logic borrow;
        count_inc = count_q;
        count_dec = count_q;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    count_inc[4*k +: 4] = 4'd0;
                end else begin
                    count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    count_dec[4*k +: 4] = 4'd9;
                end else begin
                    count_dec[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign at_max  = (count_q == MAX_BCD);
    assign at_zero = (count_q == '0);

    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (SW[2]) begin
            count_q <= LOAD_BCD;
            tc_q    <= 1'b0;
        end else if (SW[1] || !step) begin
            tc_q    <= 1'b0;
        end else if (dir_e'(SW[0]) == DIR_UP) begin
            count_q <= at_max ? '0 : count_inc;
            tc_q    <= at_max;
        end else begin
            count_q <= at_zero ? MAX_BCD : count_dec;
            tc_q    <= at_zero;
        end
    end

    assign COUNT_BCD = count_q;
    assign TC        = tc_q;

    // Scan from the top digit down; digits stay dark until the first nonzero one.
    always_comb begin
        logic lead;
        blank = '0;
        lead  = (BLANK_LZ != 0);
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (count_q[4*k +: 4] != 4'd0) lead = 1'b0;
            blank[k] = lead;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_to_seg7 u_seg (
            .bcd   (count_q[4*k +: 4]),
            .blank (blank[k]),
            .seg   (HEX[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_sync_bcd_counter.sv
// Bench for sync_bcd_counter: a 2-digit mod-60 instance driven by directed and
// random presses against an integer model, plus a 3-digit mod-1000 instance.
module tb_sync_bcd_counter;

    localparam int MOD = 60;

    logic        clk = 1'b0;
    always #10 clk = ~clk;

    logic [0:0]  key;
    logic [3:3]  vbt;
    logic [2:0]  sw;
    logic [0:13] hex;
    logic [7:0]  count_bcd;
    logic        tc;

    logic [0:0]  key3;
    logic [3:3]  vbt3;
    logic [2:0]  sw3;
    logic [0:20] hex3;
    logic [11:0] count3;
    logic        tc3;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_count;
    bit m_tc;
    logic [6:0] seg_tab [10];

    sync_bcd_counter #(.DIGITS(2), .MODULUS(60), .LOAD_VAL(45), .BLANK_LZ(1)) dut (
        .CLOCK_50  (clk),
        .KEY       (key),
        .V_BT      (vbt),
        .SW        (sw),
        .HEX       (hex),
        .COUNT_BCD (count_bcd),
        .TC        (tc)
    );

    sync_bcd_counter #(.DIGITS(3), .MODULUS(1000), .LOAD_VAL(99), .BLANK_LZ(1)) dut3 (
        .CLOCK_50  (clk),
        .KEY       (key3),
        .V_BT      (vbt3),
        .SW        (sw3),
        .HEX       (hex3),
        .COUNT_BCD (count3),
        .TC        (tc3)
    );

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        return r;
    endfunction

    function automatic logic [0:27] model_hex(input int v, input int digits);
        logic [0:27] r;
        r = '1;
        for (int k = 0; k < digits; k++) begin
            if (k > 0 && v < 10 ** k) r[7*k +: 7] = 7'b1111111;
            else                      r[7*k +: 7] = seg_tab[(v / (10 ** k)) % 10];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic check2(input string tag);
        logic [15:0] eb;
        logic [0:27] eh;
        eb = model_bcd(m_count);
        eh = model_hex(m_count, 2);
        n_cmp += 3;
        assert (count_bcd === eb[7:0]) else begin
            n_fail++;
            $error("FAIL %s COUNT_BCD: observed %h expected %h", tag, count_bcd, eb[7:0]);
        end
        assert (tc === m_tc) else begin
            n_fail++;
            $error("FAIL %s TC: observed %b expected %b", tag, tc, m_tc);
        end
        assert (hex === eh[0:13]) else begin
            n_fail++;
            $error("FAIL %s HEX: observed %b expected %b", tag, hex, eh[0:13]);
        end
    endtask

    task automatic apply_step();
        if (sw[0] == 1'b0) begin
            if (m_count == MOD - 1) begin m_count = 0; m_tc = 1'b1; end
            else m_count = m_count + 1;
        end else begin
            if (m_count == 0) begin m_count = MOD - 1; m_tc = 1'b1; end
            else m_count = m_count - 1;
        end
    endtask

    // Button held for len sampled edges; the count may only move on edge 3.
    task automatic press(input int len, input string tag);
        bit go;
        int n;
        go  = !sw[2] && !sw[1];
        n   = (len < 3) ? 3 : len;
        vbt = 1'b1;
        for (int e = 1; e <= n; e++) begin
            tick();
            m_tc = 1'b0;
            if (e == 3 && go) apply_step();
            check2(tag);
            if (e == len) vbt = 1'b0;
        end
        repeat (2) begin
            tick();
            m_tc = 1'b0;
            check2(tag);
        end
    endtask

    task automatic check3(input string tag, input int v);
        logic [15:0] eb;
        logic [0:27] eh;
        eb = model_bcd(v);
        eh = model_hex(v, 3);
        n_cmp += 3;
        assert (count3 === eb[11:0]) else begin
            n_fail++;
            $error("FAIL %s COUNT_BCD: observed %h expected %h", tag, count3, eb[11:0]);
        end
        assert (tc3 === 1'b0) else begin
            n_fail++;
            $error("FAIL %s TC: observed %b expected 0", tag, tc3);
        end
        assert (hex3 === eh[0:20]) else begin
            n_fail++;
            $error("FAIL %s HEX: observed %b expected %b", tag, hex3, eh[0:20]);
        end
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        key  = 1'b0; vbt  = 1'b0; sw  = 3'b000;
        key3 = 1'b0; vbt3 = 1'b0; sw3 = 3'b000;
        m_count = 0;
        m_tc    = 1'b0;

        repeat (3) begin tick(); check2("reset"); end
        key = 1'b1;
        repeat (2) begin tick(); check2("idle"); end

        for (int i = 0; i < 60; i++) press(int'($urandom_range(1, 4)), "up60");

        sw[0] = 1'b1;
        press(2, "down_wrap");
        press(1, "down_again");

        sw[0] = 1'b0;
        press(1000, "long_press");

        sw = 3'b100;
        tick(); m_count = 45; m_tc = 1'b0; check2("load");
        tick(); check2("load_level");
        sw = 3'b010;
        tick(); check2("hold_enter");
        repeat (3) press(2, "hold");
        sw = 3'b000;
        tick(); check2("hold_exit");

        repeat (40) begin
            sw[0] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                sw[2] = 1'b1;
                tick(); m_count = 45; m_tc = 1'b0; check2("random_load");
                sw[2] = 1'b0;
            end
            press(int'($urandom_range(1, 5)), "random");
        end

        // Reset lands on the edge the pending step would have used.
        vbt = 1'b1;
        tick(); m_tc = 1'b0; check2("pre_reset_e1");
        tick(); check2("pre_reset_e2");
        key = 1'b0;
        tick(); m_count = 0; m_tc = 1'b0; check2("mid_reset");
        key = 1'b1;
        repeat (6) begin tick(); check2("held_after_reset"); end
        vbt = 1'b0;
        repeat (3) begin tick(); check2("released_after_reset"); end
        sw[0] = 1'b0;
        press(2, "first_after_reset");

        key3 = 1'b1;
        sw3  = 3'b100;
        tick(); check3("wide_load", 99);
        sw3 = 3'b000;
        tick(); check3("wide_idle", 99);
        vbt3 = 1'b1;
        tick(); check3("wide_e1", 99);
        tick(); check3("wide_e2", 99);
        tick(); check3("wide_step", 100);
        vbt3 = 1'b0;
        repeat (2) begin tick(); check3("wide_after", 100); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_bcd_counter.md
SYNC_BCD_COUNTER -- requirements
Module: sync_bcd_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 2, number of BCD digits and displays (legal 1..4).
REQ-002 SHALL provide parameter MODULUS, default 60, count range 0..MODULUS-1 (legal 2..10^DIGITS).
REQ-003 SHALL provide parameter LOAD_VAL, default 0, preset value for load (legal 0..MODULUS-1).
REQ-004 SHALL provide parameter BLANK_LZ, default 1, 1 = blank leading-zero digits.
REQ-005 SHALL provide port CLOCK_50, in, 1, the single clock; all state on its rising edge.
REQ-006 SHALL provide port KEY[0:0], in, 1, reset: synchronous, active-low.
REQ-007 SHALL provide port V_BT[3:3], in, 1, step button, active-high, asynchronous to CLOCK_50.
REQ-008 SHALL provide port SW[2:0], in, 3: SW[0] direction (0 up, 1 down), SW[1] hold, SW[2] load; quasi-static.
REQ-009 SHALL provide port HEX[0:7*DIGITS-1], out, segments; digit k at bits 7k..7k+6, index 7k = segment a, 7k+6 = g, active-low; digit 0 least significant.
REQ-010 SHALL provide port COUNT_BCD[4*DIGITS-1:0], out, registered count, digit k at bits 4k+3..4k.
REQ-011 SHALL provide port TC, out, 1, registered one-cycle wrap pulse.

Function
REQ-012 SHALL synchronise V_BT[3] through two flops, then register the synchronised value once more for edge detection.
REQ-013 SHALL form step = synchronised value high AND previous value low; one step per button press regardless of press length.
REQ-014 SHALL update the count on the third CLOCK_50 rising edge after V_BT[3] is first sampled high.
REQ-015 SHALL apply per-edge priority: reset, then load (SW[2]=1), then hold (SW[1]=1), then step.
REQ-016 SHALL, on load, set the count to LOAD_VAL with TC=0 (level-sensitive, every edge while SW[2]=1).
REQ-017 SHALL, on hold, keep the count unchanged and discard steps arriving during hold.
REQ-018 SHALL, on an up step, increment in BCD (digit 9 -> 0 with carry); at MODULUS-1, wrap to 0 and assert TC for that one cycle.
REQ-019 SHALL, on a down step, decrement in BCD (digit 0 -> 9 with borrow); at 0, wrap to MODULUS-1 and assert TC for that one cycle.
REQ-020 SHALL hold TC low on all cycles without a wrap; the direction change takes effect on the next step.
REQ-021 SHALL decode each digit combinationally: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other value blanks (1111111).
REQ-022 SHALL, when BLANK_LZ=1, blank every digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-023 SHALL never produce a count of MODULUS or above, nor a digit above 9.

Reset
REQ-024 SHALL, on a clock edge with KEY[0]=0, clear the count to 0, TC to 0 and all synchroniser/edge flops to 0.
REQ-025 SHALL abort any step in flight on reset; a button still held at release produces no step until it is released and pressed again.
REQ-026 SHALL show digit 0 as "0", with other digits blank if BLANK_LZ=1, during and after reset.

Structure
REQ-027 SHALL keep the segment pattern constants and the blank pattern in a shared package, seg7_pkg.
REQ-028 SHALL instantiate sub-module bcd_to_seg7 (4-bit BCD plus blank -> 7 segments) once per digit via generate.
REQ-029 SHALL reject illegal parameter combinations (REQ-001..003) at elaboration.

Verification
REQ-030 SHALL cover a 60-step up-count: DIGITS=2, MODULUS=60, 60 presses up -> counts 01..59 then 00; TC high exactly one cycle at the 59 -> 00 step.
REQ-031 SHALL cover down-wrap: count 00, SW[0]=1, one press -> COUNT_BCD=0x59, TC pulse; a further press -> 0x58.
REQ-032 SHALL cover a long press: V_BT held 1000 cycles -> exactly one increment, landing on the third edge after assertion.
REQ-033 SHALL cover load and hold: SW[2]=1 with LOAD_VAL=45 -> 0x45; then SW[1]=1 with 3 presses -> stays 0x45.
REQ-034 SHALL cover mid-operation reset: KEY[0]=0 on the edge a step would land -> count 00, TC 0, HEX digit0=0000001, digit1=1111111.
REQ-035 SHALL cover a wide display: DIGITS=3, MODULUS=1000, load 099, up press -> 0x100, no TC, all three digits lit.
